// File: rtl/set_assoc_wb_cache.sv
`default_nettype none
// ==========================================================================
// set_assoc_wb_cache -- N-way set-associative write-back/write-allocate
// cache with one word per line, true-LRU replacement and a blocking miss FSM.
// Rev 1.0
// ==========================================================================
module set_assoc_wb_cache #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_resp_valid,
    output logic                  o_hit,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W;
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WAY_W-1:0] C_MAX_AGE = WAY_W'(NUM_WAYS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  req_rw_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [WAY_W-1:0]      way_q;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [INDEX_W-1:0]    in_idx_w, req_idx_w, upd_idx_w;
    logic [TAG_W-1:0]      in_tag_w, req_tag_w, upd_tag_w;
    logic                  accept_w, ack_w, hit_w, inv_found_w, vict_dirty_w;
    logic [WAY_W-1:0]      hit_way_w, vict_way_w, upd_way_w;
    logic                  upd_en_w, upd_hit_w, upd_data_en_w, upd_dirty_we_w, upd_dirty_val_w;
    logic [DATA_WIDTH-1:0] upd_data_w, resp_data_w;

    assign in_idx_w  = i_addr[INDEX_W-1:0];
    assign in_tag_w  = i_addr[ADDR_WIDTH-1:INDEX_W];
    assign req_idx_w = req_addr_q[INDEX_W-1:0];
    assign req_tag_w = req_addr_q[ADDR_WIDTH-1:INDEX_W];
    assign accept_w  = i_valid && (state_q == S_IDLE);
    assign ack_w     = mem_req_q && i_mem_ack;

    // Lookup and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit_w       = 1'b0;
        hit_way_w   = '0;
        inv_found_w = 1'b0;
        vict_way_w  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[in_idx_w][w] && (tag_q[in_idx_w][w] == in_tag_w)) begin
                hit_w     = 1'b1;
                hit_way_w = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[in_idx_w][w]) begin
                inv_found_w = 1'b1;
                vict_way_w  = WAY_W'(w);
            end
        end
        if (!inv_found_w) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[in_idx_w][w] == C_MAX_AGE) vict_way_w = WAY_W'(w);
            end
        end
        vict_dirty_w = !inv_found_w && dirty_q[in_idx_w][vict_way_w];
    end

    // One line write port shared by hits and allocations; every use also yields the response.
    always_comb begin
        upd_en_w        = 1'b0;
        upd_hit_w       = 1'b0;
        upd_idx_w       = in_idx_w;
        upd_way_w       = hit_way_w;
        upd_tag_w       = in_tag_w;
        upd_data_w      = i_wdata;
        upd_data_en_w   = 1'b0;
        upd_dirty_we_w  = 1'b0;
        upd_dirty_val_w = 1'b1;
        if (accept_w && hit_w) begin
            upd_en_w       = 1'b1;
            upd_hit_w      = 1'b1;
            upd_data_en_w  = i_rw;
            upd_dirty_we_w = i_rw;
        end else if (accept_w && i_rw && !vict_dirty_w) begin
            upd_en_w       = 1'b1;
            upd_way_w      = vict_way_w;
            upd_data_en_w  = 1'b1;
            upd_dirty_we_w = 1'b1;
        end else if (ack_w && (((state_q == S_WB) && req_rw_q) || (state_q == S_FILL))) begin
            upd_en_w        = 1'b1;
            upd_idx_w       = req_idx_w;
            upd_way_w       = way_q;
            upd_tag_w       = req_tag_w;
            upd_data_w      = req_rw_q ? req_wdata_q : i_mem_rdata;
            upd_data_en_w   = 1'b1;
            upd_dirty_we_w  = 1'b1;
            upd_dirty_val_w = req_rw_q;
        end
        resp_data_w = (upd_hit_w && !i_rw) ? data_q[in_idx_w][hit_way_w] : upd_data_w;
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept_w && !hit_w) begin
                    if (vict_dirty_w) begin
                        state_d     = S_WB;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[in_idx_w][vict_way_w], in_idx_w};
                        mem_wdata_d = data_q[in_idx_w][vict_way_w];
                    end else if (i_rw) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                    end
                end
            end
            S_WB: begin
                if (ack_w) begin
                    mem_req_d = 1'b0;
                    state_d   = req_rw_q ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                // Arriving from WB the request line sits low for one cycle before the fill goes out.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_addr_q;
                end else if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            req_rw_q     <= 1'b0;
            req_wdata_q  <= '0;
            way_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            rdata_q      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= upd_en_w;
            hit_q        <= upd_hit_w;
            if (upd_en_w) rdata_q <= resp_data_w;
            if (accept_w) begin
                req_addr_q  <= i_addr;
                req_rw_q    <= i_rw;
                req_wdata_q <= i_wdata;
                way_q       <= vict_way_w;
            end
            if (upd_en_w) begin
                valid_q[upd_idx_w][upd_way_w] <= 1'b1;
                if (upd_dirty_we_w) dirty_q[upd_idx_w][upd_way_w] <= upd_dirty_val_w;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == upd_way_w)
                        age_q[upd_idx_w][w] <= '0;
                    else if (age_q[upd_idx_w][w] < age_q[upd_idx_w][upd_way_w])
                        age_q[upd_idx_w][w] <= age_q[upd_idx_w][w] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en_w) begin
            tag_q[upd_idx_w][upd_way_w] <= upd_tag_w;
            if (upd_data_en_w) data_q[upd_idx_w][upd_way_w] <= upd_data_w;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_resp_valid = resp_valid_q;
    assign o_hit        = hit_q;
    assign o_rdata      = rdata_q;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_wb_cache.sv
`default_nettype none
// tb_set_assoc_wb_cache -- directed vector table, hand-written corner sequences and
// random traffic checked against a recency-list cache model and a word-memory model.
module tb_set_assoc_wb_cache;
    localparam int NW = 4;
    localparam int NS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_rw = 1'b0;
    logic [15:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_ready, o_resp_valid, o_hit, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_wdata;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    always #5 clk = ~clk;

    set_assoc_wb_cache #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_rw(i_rw), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_ready(o_ready), .o_resp_valid(o_resp_valid), .o_hit(o_hit),
        .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    int n_pass = 0;
    int n_chk  = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // ---------------- backing memory responder ----------------
    typedef struct { bit we; logic [15:0] addr; logic [31:0] wdata; bit stable; } txn_t;
    txn_t tlog[$];
    logic [31:0] mem [logic [15:0]];
    int   lat_cfg  = 3;
    bit   rand_lat = 1'b0;
    bit   hold_ack = 1'b0;
    bit   act = 1'b0;
    int   wait_c = 0;
    txn_t cur;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : {16'hA5A5, a};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            i_mem_ack = 1'b0;
            act = 1'b0;
        end else if (i_mem_ack) begin
            i_mem_ack = 1'b0;
            act = 1'b0;
        end else if (o_mem_req) begin
            if (!act) begin
                act = 1'b1;
                cur.we = o_mem_we; cur.addr = o_mem_addr; cur.wdata = o_mem_wdata; cur.stable = 1'b1;
                wait_c = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            end else if (o_mem_we !== cur.we || o_mem_addr !== cur.addr || o_mem_wdata !== cur.wdata) begin
                cur.stable = 1'b0;
            end
            if (!hold_ack) begin
                if (wait_c == 0) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = mem_rd(cur.addr);
                    if (cur.we) mem[cur.addr] = cur.wdata;
                    tlog.push_back(cur);
                end else begin
                    wait_c--;
                end
            end
        end
    end

    // ---------------- reference cache model ----------------
    bit          m_v [NS][NW];
    bit          m_d [NS][NW];
    logic [9:0]  m_t [NS][NW];
    logic [31:0] m_dat [NS][NW];
    int          m_ord [NS][NW];   // ways of a set, most recently used first

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < NW; p++) begin
                m_v[s][p] = 1'b0; m_d[s][p] = 1'b0; m_ord[s][p] = p;
            end
    endtask

    task automatic touch(input int s, input int way);
        int p = 0;
        for (int i = 0; i < NW; i++) if (m_ord[s][i] == way) p = i;
        for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = way;
    endtask

    task automatic predict(input bit rw, input logic [15:0] a, input logic [31:0] wd,
                           output bit hit, output logic [31:0] rd, output bit wb,
                           output logic [15:0] wba, output logic [31:0] wbd, output bit fill);
        int s = int'(a[5:0]);
        int way = -1;
        hit = 0; wb = 0; fill = 0; wba = '0; wbd = '0;
        for (int w = 0; w < NW; w++) if (m_v[s][w] && m_t[s][w] == a[15:6]) way = w;
        if (way >= 0) begin
            hit = 1;
        end else begin
            for (int w = NW - 1; w >= 0; w--) if (!m_v[s][w]) way = w;
            if (way < 0) way = m_ord[s][NW-1];
            if (m_v[s][way] && m_d[s][way]) begin
                wb = 1; wba = {m_t[s][way], a[5:0]}; wbd = m_dat[s][way];
            end
            m_v[s][way] = 1; m_t[s][way] = a[15:6]; m_d[s][way] = 0;
            if (!rw) begin fill = 1; m_dat[s][way] = mem_rd(a); end
        end
        if (rw) begin m_dat[s][way] = wd; m_d[s][way] = 1; end
        rd = m_dat[s][way];
        touch(s, way);
    endtask

    // ---------------- single request driver/checker ----------------
    task automatic run_req(input string nm, input bit rw, input logic [15:0] a, input logic [31:0] wd,
                           input bit eh, input logic [31:0] erd, input bit ewb,
                           input logic [15:0] ewa, input logic [31:0] ewd, input bit efill);
        int n = 0;
        int k = 0;
        tlog.delete();
        while (!o_ready && n < 200) begin @(negedge clk); n++; end
        if (!o_ready) chk({nm, " ready timeout"}, o_ready, 1);
        i_valid = 1; i_rw = rw; i_addr = a; i_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        i_valid = 0;
        n = 1;
        while (!o_resp_valid && n < 200) begin @(negedge clk); n++; end
        chk({nm, " resp"}, o_resp_valid, 1);
        chk({nm, " hit"}, o_hit, eh);
        if (!rw) chk({nm, " rdata"}, o_rdata, erd);
        if (eh) chk({nm, " hit latency"}, n, 1);
        chk({nm, " mem txns"}, tlog.size(), int'(ewb) + int'(efill));
        if (tlog.size() == int'(ewb) + int'(efill)) begin
            if (ewb) begin
                chk({nm, " wb we"}, tlog[0].we, 1);
                chk({nm, " wb addr"}, tlog[0].addr, ewa);
                chk({nm, " wb data"}, tlog[0].wdata, ewd);
                chk({nm, " wb stable"}, tlog[0].stable, 1);
                k = 1;
            end
            if (efill) begin
                chk({nm, " fill we"}, tlog[k].we, 0);
                chk({nm, " fill addr"}, tlog[k].addr, a);
                chk({nm, " fill stable"}, tlog[k].stable, 1);
            end
        end
    endtask

    typedef struct { bit rw; logic [15:0] addr; logic [31:0] wdata; bit hit; logic [31:0] rdata;
                     bit wb; logic [15:0] wb_addr; logic [31:0] wb_data; bit fill; } vec_t;

    function automatic vec_t mk(bit rw, logic [15:0] a, logic [31:0] wd, bit h, logic [31:0] rd,
                                bit wb, logic [15:0] wa, logic [31:0] wdd, bit f);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = wd; v.hit = h; v.rdata = rd;
        v.wb = wb; v.wb_addr = wa; v.wb_data = wdd; v.fill = f;
        return v;
    endfunction

    vec_t        vt[$];
    logic [15:0] b2b_addr [10];
    logic [31:0] b2b_exp [10];

    initial begin
        bit ph, pwb, pfl;
        logic [31:0] prd, pwbd;
        logic [15:0] pwba, ra;
        int n;

        // write then read-hit; cold read fill; set-5 eviction chain; set-7 LRU victim
        vt.push_back(mk(1, 16'h1234, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h1234, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0040, 0, 0, 32'hCAFE0001, 0, 0, 0, 1));
        vt.push_back(mk(0, 16'h0040, 0, 1, 32'hCAFE0001, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h0045, 32'h50000001, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h0085, 32'h50000002, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h00C5, 32'h50000003, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h0105, 32'h50000004, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h0145, 32'h50000005, 0, 0, 1, 16'h0045, 32'h50000001, 0));
        vt.push_back(mk(1, 16'h0185, 32'h50000006, 0, 0, 1, 16'h0085, 32'h50000002, 0));
        vt.push_back(mk(0, 16'h00C5, 0, 1, 32'h50000003, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0105, 0, 1, 32'h50000004, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0145, 0, 1, 32'h50000005, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0185, 0, 1, 32'h50000006, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0045, 0, 0, 32'h50000001, 1, 16'h00C5, 32'h50000003, 1));
        vt.push_back(mk(0, 16'h0085, 0, 0, 32'h50000002, 1, 16'h0105, 32'h50000004, 1));
        vt.push_back(mk(0, 16'h0287, 0, 0, 32'hA5A50287, 0, 0, 0, 1));
        vt.push_back(mk(0, 16'h02C7, 0, 0, 32'hA5A502C7, 0, 0, 0, 1));
        vt.push_back(mk(0, 16'h0307, 0, 0, 32'hA5A50307, 0, 0, 0, 1));
        vt.push_back(mk(0, 16'h0347, 0, 0, 32'hA5A50347, 0, 0, 0, 1));
        vt.push_back(mk(0, 16'h0287, 0, 1, 32'hA5A50287, 0, 0, 0, 0));
        vt.push_back(mk(1, 16'h0387, 32'h0E0E0E0E, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h0287, 0, 1, 32'hA5A50287, 0, 0, 0, 0));
        vt.push_back(mk(0, 16'h02C7, 0, 0, 32'hA5A502C7, 0, 0, 0, 1));

        b2b_addr = '{16'h0045, 16'h0085, 16'h0145, 16'h0185, 16'h0287,
                     16'h0387, 16'h02C7, 16'h0347, 16'h0045, 16'h0085};

        mem[16'h0040] = 32'hCAFE0001;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        chk("reset ready", o_ready, 1);
        chk("reset resp_valid", o_resp_valid, 0);
        chk("reset hit", o_hit, 0);
        chk("reset rdata", o_rdata, 0);
        chk("reset mem_req", o_mem_req, 0);
        chk("reset mem_we", o_mem_we, 0);
        chk("reset mem_addr", o_mem_addr, 0);
        chk("reset mem_wdata", o_mem_wdata, 0);
        rst_n = 1;
        @(negedge clk);

        foreach (vt[i]) begin
            predict(vt[i].rw, vt[i].addr, vt[i].wdata, ph, prd, pwb, pwba, pwbd, pfl);
            run_req($sformatf("vec%0d", i), vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].hit,
                    vt[i].rdata, vt[i].wb, vt[i].wb_addr, vt[i].wb_data, vt[i].fill);
        end

        // ten back-to-back read hits with i_valid held high
        for (int k = 0; k < 10; k++) predict(0, b2b_addr[k], 0, ph, b2b_exp[k], pwb, pwba, pwbd, pfl);
        n = 0;
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                chk($sformatf("b2b%0d resp", k - 1), o_resp_valid, 1);
                chk($sformatf("b2b%0d hit", k - 1), o_hit, 1);
                chk($sformatf("b2b%0d rdata", k - 1), o_rdata, b2b_exp[k-1]);
            end
            chk($sformatf("b2b%0d ready", k), o_ready, 1);
            chk($sformatf("b2b%0d mem_req", k), o_mem_req, 0);
            if (k < 10) begin i_valid = 1; i_rw = 0; i_addr = b2b_addr[k]; end
            else i_valid = 0;
            @(negedge clk);
        end
        chk("b2b resp ends", o_resp_valid, 0);

        // reset while a fill is outstanding
        hold_ack = 1;
        i_valid = 1; i_rw = 0; i_addr = 16'h7FC0;
        @(posedge clk);
        @(negedge clk);
        i_valid = 0;
        n = 0;
        while (!o_mem_req && n < 20) begin @(negedge clk); n++; end
        chk("rst fill req raised", o_mem_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rst mem_req async drop", o_mem_req, 0);
        chk("rst ready", o_ready, 1);
        chk("rst resp_valid", o_resp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        hold_ack = 0;
        model_reset();
        @(negedge clk);
        predict(0, 16'h1234, 0, ph, prd, pwb, pwba, pwbd, pfl);
        run_req("post-rst 0x1234", 0, 16'h1234, 0, 0, 32'hA5A51234, 0, 0, 0, 1);
        predict(0, 16'h0045, 0, ph, prd, pwb, pwba, pwbd, pfl);
        run_req("post-rst 0x0045", 0, 16'h0045, 0, 0, 32'h50000001, 0, 0, 0, 1);

        // random traffic on two sets with eight tags each
        rand_lat = 1;
        for (int i = 0; i < 300; i++) begin
            bit rw;
            logic [31:0] wd;
            ra = {7'd0, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 6'd9 : 6'd5};
            rw = $urandom_range(0, 1) != 0;
            wd = $urandom;
            predict(rw, ra, wd, ph, prd, pwb, pwba, pwbd, pfl);
            run_req($sformatf("rnd%0d", i), rw, ra, wd, ph, prd, pwb, pwba, pwbd, pfl);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
